// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry and MRET return sequencer.
// Owns mepc/mcause/mtval, the mstatus MIE/MPIE/MPP bits and the current
// privilege register. Optional macro TRAP_MTVAL_EN enables hardware mtval
// capture on trap entry; without it mtval is held at zero.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef USER
`define USER 2'b00
`endif
`ifndef SUPERVISOR
`define SUPERVISOR 2'b01
`endif
`ifndef MACHINE
`define MACHINE 2'b11
`endif
`ifndef NO_E
`define NO_E 4'hF
`endif
`ifndef E_FETCH_ADDR_MISALIGNED
`define E_FETCH_ADDR_MISALIGNED 4'd0
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR 4'd2
`endif
`ifndef E_LOAD_ADDR_MISALIGNED
`define E_LOAD_ADDR_MISALIGNED 4'd4
`endif
`ifndef E_LOAD_ACCESS_FAULT
`define E_LOAD_ACCESS_FAULT 4'd5
`endif
`ifndef E_STORE_ADDR_MISALIGNED
`define E_STORE_ADDR_MISALIGNED 4'd6
`endif
`ifndef E_STORE_ACCESS_FAULT
`define E_STORE_ACCESS_FAULT 4'd7
`endif
`ifndef E_ECALL
`define E_ECALL 4'd8
`endif

module trap_controller #(
    parameter int XLEN         = `XLEN_64b,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [3:0]                     i_exception_code_f,
    input  logic [3:0]                     i_exception_code_e,
    input  logic [(1 << (XLEN + 4)) - 1:0] i_pc_f,
    input  logic [(1 << (XLEN + 4)) - 1:0] i_pc_e,
    input  logic [31:0]                    i_instr_f,
    input  logic [(1 << (XLEN + 4)) - 1:0] i_alu_out_e,
    input  logic                           i_older_valid,
    input  logic                           i_mret_e,
    input  logic [(1 << (XLEN + 4)) - 1:0] i_mtvec,
    input  logic                           i_csr_we,
    input  logic [11:0]                    i_csr_addr,
    input  logic [(1 << (XLEN + 4)) - 1:0] i_csr_wdata,
    output logic [1:0]                     o_current_privilege,
    output logic                           o_redirect,
    output logic [(1 << (XLEN + 4)) - 1:0] o_redirect_pc,
    output logic                           o_flush_f,
    output logic                           o_flush_d,
    output logic                           o_flush_e,
    output logic                           o_stall_f,
    output logic [(1 << (XLEN + 4)) - 1:0] o_mepc,
    output logic [(1 << (XLEN + 4)) - 1:0] o_mcause,
    output logic [(1 << (XLEN + 4)) - 1:0] o_mtval,
    output logic                           o_mstatus_mie,
    output logic                           o_mstatus_mpie,
    output logic [1:0]                     o_mstatus_mpp,
    output logic                           o_trap_busy
);

    localparam int XW = 1 << (XLEN + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_WAIT,
        S_TRAP,
        S_RET,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            src_e_q, src_e_d;      // 1: flush F/D/E, 0: flush F only
    logic [3:0]      cnt_q, cnt_d;
    logic [XW-1:0]   fpc_q, fpc_d;
    logic [31:0]     finstr_q, finstr_d;
    logic [3:0]      fcode_q, fcode_d;
    logic [1:0]      priv_q, priv_d;
    logic [XW-1:0]   mepc_q, mepc_d;
    logic [XW-1:0]   mcause_q, mcause_d;
    logic [XW-1:0]   mtval_q, mtval_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [1:0]      mpp_q, mpp_d;

    logic            trap_take, trap_from_e, trap_from_latched, ret_take;
    logic [XW-1:0]   sel_pc;
    logic [31:0]     sel_instr;
    logic [3:0]      sel_code;
    logic            csr_ok;
    logic            unused_bits;

    assign unused_bits = ^{i_mtvec[1:0], i_instr_f, i_alu_out_e, finstr_q};

    // Next-state and strobe/flush/stall outputs of the trap sequencer.
    always_comb begin
        state_d           = state_q;
        src_e_d           = src_e_q;
        cnt_d             = cnt_q;
        fpc_d             = fpc_q;
        finstr_d          = finstr_q;
        fcode_d           = fcode_q;
        trap_take         = 1'b0;
        trap_from_e       = 1'b0;
        trap_from_latched = 1'b0;
        ret_take          = 1'b0;
        o_stall_f         = 1'b0;
        o_redirect        = 1'b0;
        o_redirect_pc     = '0;
        o_flush_f         = 1'b0;
        o_flush_d         = 1'b0;
        o_flush_e         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_exception_code_e != `NO_E) begin
                    trap_take   = 1'b1;
                    trap_from_e = 1'b1;
                end else if (i_mret_e) begin
                    ret_take = 1'b1;
                end else if (i_exception_code_f != `NO_E) begin
                    if (i_older_valid) begin
                        // Older instructions may still trap; hold fetch and remember F.
                        state_d   = S_F_WAIT;
                        o_stall_f = 1'b1;
                        fpc_d     = i_pc_f;
                        finstr_d  = i_instr_f;
                        fcode_d   = i_exception_code_f;
                    end else begin
                        trap_take = 1'b1;
                    end
                end
            end
            S_F_WAIT: begin
                o_stall_f = 1'b1;
                if (i_exception_code_e != `NO_E) begin
                    trap_take   = 1'b1;
                    trap_from_e = 1'b1;
                end else if (i_mret_e) begin
                    ret_take = 1'b1;
                end else if (!i_older_valid) begin
                    trap_take         = 1'b1;
                    trap_from_latched = 1'b1;
                end
            end
            S_TRAP: begin
                o_redirect    = 1'b1;
                o_redirect_pc = {i_mtvec[XW-1:2], 2'b00};
                o_flush_f     = 1'b1;
                o_flush_d     = src_e_q;
                o_flush_e     = src_e_q;
                state_d       = S_DRAIN;
                cnt_d         = 4'(FLUSH_CYCLES);
            end
            S_RET: begin
                o_redirect    = 1'b1;
                o_redirect_pc = mepc_q;
                o_flush_f     = 1'b1;
                o_flush_d     = 1'b1;
                o_flush_e     = 1'b1;
                state_d       = S_DRAIN;
                cnt_d         = 4'(FLUSH_CYCLES);
            end
            S_DRAIN: begin
                o_flush_f = 1'b1;
                o_flush_d = src_e_q;
                o_flush_e = src_e_q;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (trap_take) begin
            state_d = S_TRAP;
            src_e_d = trap_from_e;
        end
        if (ret_take) begin
            state_d = S_RET;
            src_e_d = 1'b1;
        end
    end

    // Select the trapping instruction's operands: E, latched F, or live F.
    always_comb begin
        sel_pc    = i_pc_f;
        sel_instr = i_instr_f;
        sel_code  = i_exception_code_f;
        if (trap_from_e) begin
            sel_pc    = i_pc_e;
            sel_instr = 32'd0;
            sel_code  = i_exception_code_e;
        end else if (trap_from_latched) begin
            sel_pc    = fpc_q;
            sel_instr = finstr_q;
            sel_code  = fcode_q;
        end
    end

    // CSR next values: software writes, overridden by trap/RET hardware updates.
    always_comb begin
        priv_d   = priv_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mpp_d    = mpp_q;
        csr_ok   = i_csr_we && (state_q == S_IDLE || state_q == S_F_WAIT)
                   && !trap_take && !ret_take;
        if (csr_ok) begin
            case (i_csr_addr)
                12'h341: mepc_d   = {i_csr_wdata[XW-1:2], 2'b00};
                12'h342: mcause_d = i_csr_wdata;
`ifdef TRAP_MTVAL_EN
                12'h343: mtval_d  = i_csr_wdata;
`endif
                12'h300: begin
                    mie_d  = i_csr_wdata[3];
                    mpie_d = i_csr_wdata[7];
                    mpp_d  = i_csr_wdata[12:11];
                end
                default: ;
            endcase
        end
        if (trap_take) begin
            mepc_d = sel_pc;
            if (sel_code == `E_ECALL) begin
                mcause_d = {{(XW-4){1'b0}}, 4'd8 + {2'b00, priv_q}};
            end else begin
                mcause_d = {{(XW-4){1'b0}}, sel_code};
            end
`ifdef TRAP_MTVAL_EN
            case (sel_code)
                `E_FETCH_ADDR_MISALIGNED: mtval_d = sel_pc;
                `E_ILLEGAL_INSTR:         mtval_d = {{(XW-32){1'b0}}, sel_instr};
                `E_LOAD_ADDR_MISALIGNED,
                `E_LOAD_ACCESS_FAULT,
                `E_STORE_ADDR_MISALIGNED,
                `E_STORE_ACCESS_FAULT:    mtval_d = i_alu_out_e;
                default:                  mtval_d = '0;
            endcase
`else
            mtval_d = '0;
`endif
            mpie_d = mie_q;
            mie_d  = 1'b0;
            mpp_d  = priv_q;
            priv_d = `MACHINE;
        end
        if (ret_take) begin
            priv_d = mpp_q;
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = `USER;
        end
    end

    // State and CSR registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            src_e_q  <= 1'b0;
            cnt_q    <= 4'd0;
            fpc_q    <= '0;
            finstr_q <= 32'd0;
            fcode_q  <= `NO_E;
            priv_q   <= `MACHINE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mpp_q    <= `MACHINE;
        end else begin
            state_q  <= state_d;
            src_e_q  <= src_e_d;
            cnt_q    <= cnt_d;
            fpc_q    <= fpc_d;
            finstr_q <= finstr_d;
            fcode_q  <= fcode_d;
            priv_q   <= priv_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mpp_q    <= mpp_d;
        end
    end

    assign o_current_privilege = priv_q;
    assign o_mepc              = mepc_q;
    assign o_mcause            = mcause_q;
    assign o_mtval             = mtval_q;
    assign o_mstatus_mie       = mie_q;
    assign o_mstatus_mpie      = mpie_q;
    assign o_mstatus_mpp       = mpp_q;
    assign o_trap_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: table-driven per-cycle vectors plus a hand-written
// ECALL-from-M sequence with bounded waits, for trap_controller (XW = 64).

module tb_trap_controller;

    localparam logic [3:0] N = 4'hF;   // no exception

`ifdef TRAP_MTVAL_EN
    localparam bit MTV = 1'b1;
`else
    localparam bit MTV = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  cf, ce;
        logic [63:0] pcf, pce;
        logic [31:0] instr;
        logic [63:0] alu;
        logic        older, mret, we;
        logic [11:0] addr;
        logic [63:0] wdata;
        bit          chk;
        logic [1:0]  priv;
        logic        redir;
        logic [63:0] rpc;
        logic [2:0]  fl;
        logic        stall, busy;
        logic [63:0] mepc, mcause, mtval;
        logic        mie, mpie;
        logic [1:0]  mpp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  code_f, code_e;
    logic [63:0] pc_f, pc_e, alu_out, mtvec, csr_wdata;
    logic [31:0] instr_f;
    logic        older_valid, mret_e, csr_we;
    logic [11:0] csr_addr;
    logic [1:0]  priv;
    logic        redirect, flush_f, flush_d, flush_e, stall_f, busy;
    logic [63:0] redirect_pc, mepc, mcause, mtval;
    logic        mie, mpie;
    logic [1:0]  mpp;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t cur;

    always #5 clk = ~clk;

    trap_controller dut (
        .i_clk(clk), .i_rst(rst),
        .i_exception_code_f(code_f), .i_exception_code_e(code_e),
        .i_pc_f(pc_f), .i_pc_e(pc_e), .i_instr_f(instr_f), .i_alu_out_e(alu_out),
        .i_older_valid(older_valid), .i_mret_e(mret_e), .i_mtvec(mtvec),
        .i_csr_we(csr_we), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .o_current_privilege(priv), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
        .o_flush_f(flush_f), .o_flush_d(flush_d), .o_flush_e(flush_e), .o_stall_f(stall_f),
        .o_mepc(mepc), .o_mcause(mcause), .o_mtval(mtval),
        .o_mstatus_mie(mie), .o_mstatus_mpie(mpie), .o_mstatus_mpp(mpp),
        .o_trap_busy(busy)
    );

    function automatic logic [63:0] mt(input logic [63:0] v);
        return MTV ? v : 64'd0;
    endfunction

    task automatic vi(input logic r, input logic [3:0] cf, input logic [3:0] ce,
                      input logic [63:0] pcf, input logic [63:0] pce, input logic [31:0] ins,
                      input logic [63:0] alu, input logic old, input logic mr,
                      input logic we, input logic [11:0] ad, input logic [63:0] wd);
        cur.rst = r; cur.cf = cf; cur.ce = ce; cur.pcf = pcf; cur.pce = pce;
        cur.instr = ins; cur.alu = alu; cur.older = old; cur.mret = mr;
        cur.we = we; cur.addr = ad; cur.wdata = wd;
    endtask

    task automatic idle_in();
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    endtask

    task automatic ve(input string nm, input bit ck, input logic [1:0] pv, input logic rd,
                      input logic [63:0] rp, input logic [2:0] fl, input logic st,
                      input logic bz, input logic [63:0] ep, input logic [63:0] ca,
                      input logic [63:0] tv, input logic ie, input logic pie,
                      input logic [1:0] pp);
        cur.name = nm; cur.chk = ck; cur.priv = pv; cur.redir = rd; cur.rpc = rp;
        cur.fl = fl; cur.stall = st; cur.busy = bz; cur.mepc = ep; cur.mcause = ca;
        cur.mtval = tv; cur.mie = ie; cur.mpie = pie; cur.mpp = pp;
        vecs.push_back(cur);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; code_f = v.cf; code_e = v.ce; pc_f = v.pcf; pc_e = v.pce;
        instr_f = v.instr; alu_out = v.alu; older_valid = v.older; mret_e = v.mret;
        csr_we = v.we; csr_addr = v.addr; csr_wdata = v.wdata;
    endtask

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        mtvec = 64'h8001;
        idle_in(); drive(cur);
        rst = 1'b1;

        // ---- vector table: inputs for a cycle, outputs expected in that cycle ----
        vi(1, N, N, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
        ve("pre_reset", 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        idle_in();                                    ve("reset_state", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h80);
        ve("wr_mstatus", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 1, 12'h341, 64'h403);
        ve("wr_mepc", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vi(0, N, N, 0, 0, 0, 0, 0, 1, 0, 12'h000, 0);
        ve("mret_to_u", 1, 3, 0, 0, 0, 0, 0, 64'h400, 0, 0, 0, 1, 0);
        idle_in();  ve("ret_redirect", 1, 0, 1, 64'h400, 3'b111, 0, 1, 64'h400, 0, 0, 1, 1, 0);
        idle_in();  ve("ret_drain1", 1, 0, 0, 0, 3'b111, 0, 1, 64'h400, 0, 0, 1, 1, 0);
        idle_in();  ve("ret_drain2", 1, 0, 0, 0, 3'b111, 0, 1, 64'h400, 0, 0, 1, 1, 0);
        vi(0, N, 4'd5, 0, 64'h1000, 0, 64'h2003, 0, 0, 0, 12'h000, 0);
        ve("ld_fault_in", 1, 0, 0, 0, 0, 0, 0, 64'h400, 0, 0, 1, 1, 0);
        idle_in();  ve("ld_fault_trap", 1, 3, 1, 64'h8000, 3'b111, 0, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        idle_in();  ve("ld_drain1", 1, 3, 0, 0, 3'b111, 0, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        idle_in();  ve("ld_drain2", 1, 3, 0, 0, 3'b111, 0, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        vi(0, 4'd2, N, 64'h3000, 0, 32'hDEADBEEF, 0, 1, 0, 0, 12'h000, 0);
        ve("ill_wait0", 1, 3, 0, 0, 0, 1, 0, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        vi(0, N, N, 64'h3333, 0, 0, 0, 1, 0, 0, 12'h000, 0);
        ve("ill_wait1", 1, 3, 0, 0, 0, 1, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        vi(0, N, N, 64'h3333, 0, 0, 0, 1, 0, 0, 12'h000, 0);
        ve("ill_wait2", 1, 3, 0, 0, 0, 1, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        vi(0, N, N, 64'h3333, 0, 0, 0, 0, 0, 0, 12'h000, 0);
        ve("ill_drop", 1, 3, 0, 0, 0, 1, 1, 64'h1000, 5, mt(64'h2003), 0, 1, 0);
        idle_in();  ve("ill_trap", 1, 3, 1, 64'h8000, 3'b100, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 0, 0, 3);
        vi(0, N, 4'd5, 0, 64'h5000, 0, 64'h1, 0, 0, 0, 12'h000, 0);
        ve("drain_e_ignored", 1, 3, 0, 0, 3'b100, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 0, 0, 3);
        vi(0, N, 4'd5, 0, 64'h5000, 0, 64'h1, 0, 1, 1, 12'h341, 64'h1234);
        ve("drain_wr_ignored", 1, 3, 0, 0, 3'b100, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h80);
        ve("wr_mstatus2", 1, 3, 0, 0, 0, 0, 0, 64'h3000, 2, mt(64'hDEADBEEF), 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 1, 0, 12'h000, 0);
        ve("mret_to_u2", 1, 3, 0, 0, 0, 0, 0, 64'h3000, 2, mt(64'hDEADBEEF), 0, 1, 0);
        idle_in();  ve("ret2_redirect", 1, 0, 1, 64'h3000, 3'b111, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 1, 1, 0);
        idle_in();  ve("ret2_drain1", 1, 0, 0, 0, 3'b111, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 1, 1, 0);
        idle_in();  ve("ret2_drain2", 1, 0, 0, 0, 3'b111, 0, 1, 64'h3000, 2, mt(64'hDEADBEEF), 1, 1, 0);
        vi(0, 4'd0, N, 64'h6002, 0, 0, 0, 1, 0, 0, 12'h000, 0);
        ve("fmis_wait", 1, 0, 0, 0, 0, 1, 0, 64'h3000, 2, mt(64'hDEADBEEF), 1, 1, 0);
        vi(0, N, 4'd8, 0, 64'h7000, 0, 0, 1, 0, 0, 12'h000, 0);
        ve("ecall_abandons_f", 1, 0, 0, 0, 0, 1, 1, 64'h3000, 2, mt(64'hDEADBEEF), 1, 1, 0);
        idle_in();  ve("ecall_u_trap", 1, 3, 1, 64'h8000, 3'b111, 0, 1, 64'h7000, 8, 0, 0, 1, 0);
        idle_in();  ve("ecall_drain1", 1, 3, 0, 0, 3'b111, 0, 1, 64'h7000, 8, 0, 0, 1, 0);
        idle_in();  ve("ecall_drain2", 1, 3, 0, 0, 3'b111, 0, 1, 64'h7000, 8, 0, 0, 1, 0);
        vi(0, N, N, 0, 0, 0, 0, 0, 1, 1, 12'h341, 64'h9999);
        ve("mret_wr_drop", 1, 3, 0, 0, 0, 0, 0, 64'h7000, 8, 0, 0, 1, 0);
        idle_in();  ve("ret3_redirect", 1, 0, 1, 64'h7000, 3'b111, 0, 1, 64'h7000, 8, 0, 1, 1, 0);
        idle_in();  ve("ret3_drain1", 1, 0, 0, 0, 3'b111, 0, 1, 64'h7000, 8, 0, 1, 1, 0);
        idle_in();  ve("ret3_drain2", 1, 0, 0, 0, 3'b111, 0, 1, 64'h7000, 8, 0, 1, 1, 0);
        vi(0, N, 4'd6, 0, 64'h1100, 0, 64'h2201, 0, 0, 1, 12'h341, 64'hAAAA);
        ve("st_mis_wr_drop", 1, 0, 0, 0, 0, 0, 0, 64'h7000, 8, 0, 1, 1, 0);
        idle_in();  ve("st_mis_trap", 1, 3, 1, 64'h8000, 3'b111, 0, 1, 64'h1100, 6, mt(64'h2201), 0, 1, 0);
        vi(1, N, N, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
        ve("rst_in_drain", 1, 3, 0, 0, 3'b111, 0, 1, 64'h1100, 6, mt(64'h2201), 0, 1, 0);
        idle_in();  ve("after_rst", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 1, 12'h343, 64'h55);
        ve("wr_mtval", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vi(0, N, N, 0, 0, 0, 0, 0, 0, 1, 12'h342, 64'h1F);
        ve("wr_mcause", 1, 3, 0, 0, 0, 0, 0, 0, 0, mt(64'h55), 0, 0, 3);
        idle_in();  ve("csr_visible", 1, 3, 0, 0, 0, 0, 0, 0, 64'h1F, mt(64'h55), 0, 0, 3);

        // ---- apply table: drive after posedge, sample at negedge ----
        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                tests++;
                if ({priv, redirect, redirect_pc, flush_f, flush_d, flush_e, stall_f, busy,
                     mepc, mcause, mtval, mie, mpie, mpp} !==
                    {vecs[i].priv, vecs[i].redir, vecs[i].rpc, vecs[i].fl, vecs[i].stall,
                     vecs[i].busy, vecs[i].mepc, vecs[i].mcause, vecs[i].mtval, vecs[i].mie,
                     vecs[i].mpie, vecs[i].mpp}) begin
                    fails++;
                    $display("FAIL %s: got priv=%0d redir=%0b rpc=%0h fl=%0b%0b%0b stall=%0b busy=%0b mepc=%0h mcause=%0h mtval=%0h mie=%0b mpie=%0b mpp=%0d | expected priv=%0d redir=%0b rpc=%0h fl=%03b stall=%0b busy=%0b mepc=%0h mcause=%0h mtval=%0h mie=%0b mpie=%0b mpp=%0d",
                             vecs[i].name, priv, redirect, redirect_pc, flush_f, flush_d, flush_e,
                             stall_f, busy, mepc, mcause, mtval, mie, mpie, mpp,
                             vecs[i].priv, vecs[i].redir, vecs[i].rpc, vecs[i].fl, vecs[i].stall,
                             vecs[i].busy, vecs[i].mepc, vecs[i].mcause, vecs[i].mtval,
                             vecs[i].mie, vecs[i].mpie, vecs[i].mpp);
                end else begin
                    $display("[TB] vec %0d %s ok", i, vecs[i].name);
                end
            end
            @(posedge clk); #1;
        end

        // ---- hand sequence: ECALL from M-mode, bounded waits on redirect/flush ----
        begin
            bit found = 1'b0;
            int flush_len = 0;
            idle_in(); drive(cur);
            code_e = 4'd8; pc_e = 64'h2468;
            @(posedge clk); #1;
            code_e = N;
            for (int k = 0; k < 10 && !found; k++) begin
                @(negedge clk);
                if (redirect) found = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check1("ecall_m_redirect_seen", {63'd0, found}, 64'd1);
            check1("ecall_m_mcause", mcause, 64'd11);
            check1("ecall_m_mepc", mepc, 64'h2468);
            check1("ecall_m_mtval", mtval, 64'd0);
            while (flush_e && flush_len < 20) begin
                flush_len++;
                @(posedge clk); #1;
                @(negedge clk);
            end
            check1("ecall_m_flush_len", 64'(flush_len), 64'd3);
            check1("ecall_m_back_idle", {63'd0, busy}, 64'd0);
            $display("[TB] ecall_m sequence flush_len=%0d", flush_len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
